// File: rtl/softmax_row_ctrl.sv
// softmax_row_ctrl: drives a softmax engine from the initiator side.
// A serial score stream is packed into one DIM-wide row. Start is held until
// the engine reports valid. The result vector is captured and then replayed
// as a serial valid/ready stream.
module softmax_row_ctrl #(
   parameter int D_W = 16,
   parameter int DIM = 16,
   parameter int TMO = 4095
) (
   input  logic                 I_CLK,
   input  logic                 I_RST,
   input  logic                 I_S_VLD,
   output logic                 O_S_RDY,
   input  logic [D_W-1:0]       I_S_DATA,
   input  logic                 I_S_LAST,
   output logic                 O_SM_START,
   output logic [D_W*DIM-1:0]   O_SM_DATA,
   input  logic                 I_SM_VLD,
   input  logic [D_W*DIM-1:0]   I_SM_DATA,
   output logic                 O_M_VLD,
   input  logic                 I_M_RDY,
   output logic [D_W-1:0]       O_M_DATA,
   output logic                 O_M_LAST,
   output logic                 O_BUSY,
   output logic                 O_ERR_LEN,
   output logic                 O_ERR_TMO,
   input  logic                 I_CLR_ERR
);

   localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int TMO_W = (TMO > 1) ? $clog2(TMO + 1) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIM - 1);
   // The counter is compared one cycle early so the flag lands exactly TMO
   // cycles after start rises.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

   typedef enum logic [1:0] {S_FILL, S_CALC, S_DRAIN} state_t;

   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         cnt, cnt_nxt;
   logic [TMO_W-1:0]         tmo_cnt, tmo_nxt;
   logic [DIM-1:0][D_W-1:0]  row_q, res_q;
   logic                     s_rdy, m_vld, sm_start;
   logic                     set_len, set_tmo, tmo_hit;
   logic                     err_len, err_tmo;

   assign tmo_hit = (TMO != 0) && (tmo_cnt == TMO_LAST);

   // State register, counters and the row/result storage.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state   <= S_FILL;
         cnt     <= '0;
         tmo_cnt <= '0;
         row_q   <= '0;
         res_q   <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         tmo_cnt <= tmo_nxt;
         if (state == S_FILL && I_S_VLD)
            row_q[cnt] <= I_S_DATA;
         if (state == S_CALC && I_SM_VLD)
            res_q <= I_SM_DATA;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tmo_nxt   = tmo_cnt;
      set_len   = 1'b0;
      set_tmo   = 1'b0;
      s_rdy     = 1'b0;
      m_vld     = 1'b0;
      sm_start  = 1'b0;
      case (state)
         S_FILL: begin
            s_rdy = 1'b1;
            if (I_S_VLD) begin
               if (cnt == LAST_IDX) begin
                  // A full row is complete even without LAST; flag the mismatch.
                  set_len   = ~I_S_LAST;
                  cnt_nxt   = '0;
                  tmo_nxt   = '0;
                  state_nxt = S_CALC;
               end else if (I_S_LAST) begin
                  // Short row: flag it and start the row over.
                  set_len = 1'b1;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         S_CALC: begin
            // Start drops in the valid cycle so the engine cannot re-arm.
            sm_start = ~I_SM_VLD;
            tmo_nxt  = tmo_cnt + 1'b1;
            if (I_SM_VLD) begin
               state_nxt = S_DRAIN;
            end else if (tmo_hit) begin
               set_tmo   = 1'b1;
               state_nxt = S_FILL;
            end
         end
         S_DRAIN: begin
            m_vld = 1'b1;
            if (I_M_RDY) begin
               if (cnt == LAST_IDX) begin
                  cnt_nxt   = '0;
                  state_nxt = S_FILL;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: state_nxt = S_FILL;
      endcase
   end

   // Sticky error flags; a new error in the clear cycle wins.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         err_len <= 1'b0;
         err_tmo <= 1'b0;
      end else begin
         if (set_len)        err_len <= 1'b1;
         else if (I_CLR_ERR) err_len <= 1'b0;
         if (set_tmo)        err_tmo <= 1'b1;
         else if (I_CLR_ERR) err_tmo <= 1'b0;
      end
   end

   assign O_S_RDY    = s_rdy & ~I_RST;
   assign O_SM_START = sm_start;
   assign O_SM_DATA  = row_q;
   assign O_M_VLD    = m_vld;
   assign O_M_DATA   = m_vld ? res_q[cnt] : '0;
   assign O_M_LAST   = m_vld && (cnt == LAST_IDX);
   assign O_BUSY     = (state != S_FILL) || (cnt != '0);
   assign O_ERR_LEN  = err_len;
   assign O_ERR_TMO  = err_tmo;

endmodule

// File: tb/tb_softmax_row_ctrl.sv
// Directed bench for softmax_row_ctrl; the engine is emulated by the tasks.
module tb_softmax_row_ctrl;

   localparam int D_W = 16;
   localparam int DIM = 16;
   localparam int TMO = 64;

   logic                 I_CLK = 1'b0;
   logic                 I_RST = 1'b1;
   logic                 I_S_VLD = 1'b0;
   logic                 O_S_RDY;
   logic [D_W-1:0]       I_S_DATA = '0;
   logic                 I_S_LAST = 1'b0;
   logic                 O_SM_START;
   logic [D_W*DIM-1:0]   O_SM_DATA;
   logic                 I_SM_VLD = 1'b0;
   logic [D_W*DIM-1:0]   I_SM_DATA = '0;
   logic                 O_M_VLD;
   logic                 I_M_RDY = 1'b1;
   logic [D_W-1:0]       O_M_DATA;
   logic                 O_M_LAST;
   logic                 O_BUSY;
   logic                 O_ERR_LEN;
   logic                 O_ERR_TMO;
   logic                 I_CLR_ERR = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   logic [D_W*DIM-1:0] res_vec, row_exp;

   softmax_row_ctrl #(.D_W(D_W), .DIM(DIM), .TMO(TMO)) dut (
      .I_CLK(I_CLK), .I_RST(I_RST),
      .I_S_VLD(I_S_VLD), .O_S_RDY(O_S_RDY), .I_S_DATA(I_S_DATA), .I_S_LAST(I_S_LAST),
      .O_SM_START(O_SM_START), .O_SM_DATA(O_SM_DATA),
      .I_SM_VLD(I_SM_VLD), .I_SM_DATA(I_SM_DATA),
      .O_M_VLD(O_M_VLD), .I_M_RDY(I_M_RDY), .O_M_DATA(O_M_DATA), .O_M_LAST(O_M_LAST),
      .O_BUSY(O_BUSY), .O_ERR_LEN(O_ERR_LEN), .O_ERR_TMO(O_ERR_TMO), .I_CLR_ERR(I_CLR_ERR)
   );

   always #5 I_CLK = ~I_CLK;

   // Send n beats 0x0100*(i+1); LAST on beat index last_idx. Returns at the
   // falling edge just after the final beat was accepted.
   task automatic send_row(input int n, input int last_idx);
      for (int i = 0; i < n; i++) begin
         @(negedge I_CLK);
         I_S_VLD  = 1'b1;
         I_S_DATA = D_W'((i + 1) * 256);
         I_S_LAST = (i == last_idx);
      end
      @(negedge I_CLK);
      I_S_VLD  = 1'b0;
      I_S_LAST = 1'b0;
      I_S_DATA = '0;
   endtask

   // Engine model: pulse valid lat cycles after start rose. Called at the
   // falling edge of the first start-high cycle; returns in drain cycle 0.
   task automatic run_engine(input int lat);
      repeat (lat) @(negedge I_CLK);
      I_SM_VLD  = 1'b1;
      I_SM_DATA = res_vec;
      @(negedge I_CLK);
      I_SM_VLD  = 1'b0;
      I_SM_DATA = '0;
   endtask

   task automatic clr_pulse();
      @(negedge I_CLK);
      I_CLR_ERR = 1'b1;
      @(negedge I_CLK);
      I_CLR_ERR = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge I_CLK);
      #1;
      n_tests++; if (O_S_RDY !== 1'b0) begin n_fail++; $display("FAIL rst_srdy got %0b exp 0", O_S_RDY); end
      n_tests++; if (O_SM_START !== 1'b0) begin n_fail++; $display("FAIL rst_start got %0b exp 0", O_SM_START); end
      n_tests++; if (O_M_VLD !== 1'b0) begin n_fail++; $display("FAIL rst_mvld got %0b exp 0", O_M_VLD); end
      n_tests++; if (O_SM_DATA !== '0) begin n_fail++; $display("FAIL rst_smdata got %h exp 0", O_SM_DATA); end
      n_tests++; if ({O_BUSY, O_ERR_LEN, O_ERR_TMO, O_M_LAST} !== 4'b0) begin n_fail++; $display("FAIL rst_flags got %b exp 0000", {O_BUSY, O_ERR_LEN, O_ERR_TMO, O_M_LAST}); end
      I_RST = 1'b0;
      #1;
      n_tests++; if (O_S_RDY !== 1'b1) begin n_fail++; $display("FAIL rel_srdy got %0b exp 1", O_S_RDY); end
      n_tests++; if (O_BUSY !== 1'b0) begin n_fail++; $display("FAIL rel_busy got %0b exp 0", O_BUSY); end
   endtask

   task automatic test_basic();
      send_row(16, 15);
      n_tests++; if (O_SM_DATA !== row_exp) begin n_fail++; $display("FAIL basic_row got %h exp %h", O_SM_DATA, row_exp); end
      n_tests++; if (O_S_RDY !== 1'b0) begin n_fail++; $display("FAIL basic_srdy_calc got %0b exp 0", O_S_RDY); end
      n_tests++; if (O_BUSY !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %0b exp 1", O_BUSY); end
      for (int i = 0; i < 40; i++) begin
         n_tests++; if (O_SM_START !== 1'b1) begin n_fail++; $display("FAIL basic_start_c%0d got %0b exp 1", i, O_SM_START); end
         @(negedge I_CLK);
      end
      I_SM_VLD  = 1'b1;
      I_SM_DATA = res_vec;
      #1;
      n_tests++; if (O_SM_START !== 1'b0) begin n_fail++; $display("FAIL basic_start_vld got %0b exp 0", O_SM_START); end
      @(negedge I_CLK);
      I_SM_VLD  = 1'b0;
      I_SM_DATA = '0;
      for (int k = 0; k < 16; k++) begin
         n_tests++; if (O_M_VLD !== 1'b1) begin n_fail++; $display("FAIL basic_mvld_%0d got %0b exp 1", k, O_M_VLD); end
         n_tests++; if (O_M_DATA !== D_W'(k + 1)) begin n_fail++; $display("FAIL basic_mdata_%0d got %h exp %h", k, O_M_DATA, D_W'(k + 1)); end
         n_tests++; if (O_M_LAST !== (k == 15)) begin n_fail++; $display("FAIL basic_mlast_%0d got %0b exp %0b", k, O_M_LAST, (k == 15)); end
         @(negedge I_CLK);
      end
      n_tests++; if (O_M_VLD !== 1'b0) begin n_fail++; $display("FAIL basic_mvld_end got %0b exp 0", O_M_VLD); end
      n_tests++; if (O_S_RDY !== 1'b1) begin n_fail++; $display("FAIL basic_srdy_end got %0b exp 1", O_S_RDY); end
      n_tests++; if ({O_ERR_LEN, O_ERR_TMO, O_BUSY} !== 3'b0) begin n_fail++; $display("FAIL basic_flags got %b exp 000", {O_ERR_LEN, O_ERR_TMO, O_BUSY}); end
   endtask

   task automatic test_backpressure();
      int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      int k = 0;
      int c = 0;
      send_row(16, 15);
      run_engine(40);
      while (k < 16 && c < 200) begin
         I_M_RDY = pat[c % 7][0];
         #1;
         n_tests++; if (O_M_VLD !== 1'b1) begin n_fail++; $display("FAIL bp_mvld_c%0d got %0b exp 1", c, O_M_VLD); end
         n_tests++; if (O_M_DATA !== D_W'(k + 1)) begin n_fail++; $display("FAIL bp_mdata_c%0d got %h exp %h", c, O_M_DATA, D_W'(k + 1)); end
         n_tests++; if (O_M_LAST !== (k == 15)) begin n_fail++; $display("FAIL bp_mlast_c%0d got %0b exp %0b", c, O_M_LAST, (k == 15)); end
         if (I_M_RDY) k++;
         c++;
         @(negedge I_CLK);
      end
      I_M_RDY = 1'b1;
      #1;
      n_tests++; if (k != 16) begin n_fail++; $display("FAIL bp_handshakes got %0d exp 16", k); end
      n_tests++; if (O_S_RDY !== 1'b1) begin n_fail++; $display("FAIL bp_srdy_end got %0b exp 1", O_S_RDY); end
      n_tests++; if (O_M_VLD !== 1'b0) begin n_fail++; $display("FAIL bp_mvld_end got %0b exp 0", O_M_VLD); end
   endtask

   task automatic test_early_last();
      send_row(5, 4);
      n_tests++; if (O_ERR_LEN !== 1'b1) begin n_fail++; $display("FAIL el_err got %0b exp 1", O_ERR_LEN); end
      n_tests++; if (O_S_RDY !== 1'b1) begin n_fail++; $display("FAIL el_srdy got %0b exp 1", O_S_RDY); end
      n_tests++; if (O_BUSY !== 1'b0) begin n_fail++; $display("FAIL el_busy got %0b exp 0", O_BUSY); end
      for (int i = 0; i < 4; i++) begin
         n_tests++; if (O_SM_START !== 1'b0) begin n_fail++; $display("FAIL el_start_c%0d got %0b exp 0", i, O_SM_START); end
         @(negedge I_CLK);
      end
      send_row(16, 15);
      n_tests++; if (O_SM_START !== 1'b1) begin n_fail++; $display("FAIL el_start2 got %0b exp 1", O_SM_START); end
      n_tests++; if (O_SM_DATA !== row_exp) begin n_fail++; $display("FAIL el_row2 got %h exp %h", O_SM_DATA, row_exp); end
      run_engine(40);
      for (int k = 0; k < 16; k++) begin
         n_tests++; if (O_M_DATA !== D_W'(k + 1)) begin n_fail++; $display("FAIL el_mdata_%0d got %h exp %h", k, O_M_DATA, D_W'(k + 1)); end
         n_tests++; if (O_ERR_LEN !== 1'b1) begin n_fail++; $display("FAIL el_sticky_%0d got %0b exp 1", k, O_ERR_LEN); end
         @(negedge I_CLK);
      end
      clr_pulse();
      n_tests++; if (O_ERR_LEN !== 1'b0) begin n_fail++; $display("FAIL el_clr got %0b exp 0", O_ERR_LEN); end
   endtask

   task automatic test_timeout();
      send_row(16, 15);
      for (int i = 0; i < TMO; i++) begin
         n_tests++; if (O_SM_START !== 1'b1) begin n_fail++; $display("FAIL tmo_start_c%0d got %0b exp 1", i, O_SM_START); end
         n_tests++; if (O_ERR_TMO !== 1'b0) begin n_fail++; $display("FAIL tmo_early_c%0d got %0b exp 0", i, O_ERR_TMO); end
         @(negedge I_CLK);
      end
      n_tests++; if (O_ERR_TMO !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %0b exp 1", O_ERR_TMO); end
      n_tests++; if (O_SM_START !== 1'b0) begin n_fail++; $display("FAIL tmo_start_drop got %0b exp 0", O_SM_START); end
      n_tests++; if (O_S_RDY !== 1'b1) begin n_fail++; $display("FAIL tmo_srdy got %0b exp 1", O_S_RDY); end
      I_SM_VLD  = 1'b1;
      I_SM_DATA = res_vec;
      @(negedge I_CLK);
      I_SM_VLD  = 1'b0;
      I_SM_DATA = '0;
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (O_M_VLD !== 1'b0) begin n_fail++; $display("FAIL tmo_late_vld_c%0d got %0b exp 0", i, O_M_VLD); end
         n_tests++; if (O_S_RDY !== 1'b1) begin n_fail++; $display("FAIL tmo_late_srdy_c%0d got %0b exp 1", i, O_S_RDY); end
         @(negedge I_CLK);
      end
      clr_pulse();
      n_tests++; if (O_ERR_TMO !== 1'b0) begin n_fail++; $display("FAIL tmo_clr got %0b exp 0", O_ERR_TMO); end
   endtask

   task automatic test_reset_mid();
      send_row(16, 15);
      run_engine(40);
      repeat (7) @(negedge I_CLK);
      n_tests++; if (O_M_DATA !== D_W'(8)) begin n_fail++; $display("FAIL rm_beat7 got %h exp 0008", O_M_DATA); end
      I_RST = 1'b1;
      #1;
      n_tests++; if ({O_S_RDY, O_M_VLD, O_M_LAST, O_SM_START, O_BUSY} !== 5'b0) begin n_fail++; $display("FAIL rm_ctrl got %b exp 00000", {O_S_RDY, O_M_VLD, O_M_LAST, O_SM_START, O_BUSY}); end
      n_tests++; if (O_M_DATA !== '0) begin n_fail++; $display("FAIL rm_mdata got %h exp 0", O_M_DATA); end
      n_tests++; if (O_SM_DATA !== '0) begin n_fail++; $display("FAIL rm_smdata got %h exp 0", O_SM_DATA); end
      @(negedge I_CLK);
      I_RST = 1'b0;
      #1;
      n_tests++; if (O_S_RDY !== 1'b1) begin n_fail++; $display("FAIL rm_srdy got %0b exp 1", O_S_RDY); end
      n_tests++; if (O_BUSY !== 1'b0) begin n_fail++; $display("FAIL rm_busy got %0b exp 0", O_BUSY); end
      send_row(16, 15);
      n_tests++; if (O_SM_DATA !== row_exp) begin n_fail++; $display("FAIL rm_row got %h exp %h", O_SM_DATA, row_exp); end
      run_engine(40);
      for (int k = 0; k < 16; k++) begin
         n_tests++; if (O_M_DATA !== D_W'(k + 1)) begin n_fail++; $display("FAIL rm_mdata_%0d got %h exp %h", k, O_M_DATA, D_W'(k + 1)); end
         n_tests++; if (O_M_LAST !== (k == 15)) begin n_fail++; $display("FAIL rm_mlast_%0d got %0b exp %0b", k, O_M_LAST, (k == 15)); end
         @(negedge I_CLK);
      end
      n_tests++; if (O_S_RDY !== 1'b1) begin n_fail++; $display("FAIL rm_srdy_end got %0b exp 1", O_S_RDY); end
   endtask

   task automatic test_clr_collision();
      n_tests++; if (O_ERR_LEN !== 1'b0) begin n_fail++; $display("FAIL cc_pre got %0b exp 0", O_ERR_LEN); end
      for (int i = 0; i < 4; i++) begin
         @(negedge I_CLK);
         I_S_VLD   = 1'b1;
         I_S_DATA  = D_W'((i + 1) * 256);
         I_S_LAST  = (i == 3);
         I_CLR_ERR = (i == 3);
      end
      @(negedge I_CLK);
      I_S_VLD   = 1'b0;
      I_S_LAST  = 1'b0;
      I_CLR_ERR = 1'b0;
      n_tests++; if (O_ERR_LEN !== 1'b1) begin n_fail++; $display("FAIL cc_setwins got %0b exp 1", O_ERR_LEN); end
      n_tests++; if (O_S_RDY !== 1'b1) begin n_fail++; $display("FAIL cc_srdy got %0b exp 1", O_S_RDY); end
      clr_pulse();
      n_tests++; if (O_ERR_LEN !== 1'b0) begin n_fail++; $display("FAIL cc_clr got %0b exp 0", O_ERR_LEN); end
   endtask

   initial begin
      for (int k = 0; k < DIM; k++) begin
         res_vec[D_W*k +: D_W] = D_W'(k + 1);
         row_exp[D_W*k +: D_W] = D_W'((k + 1) * 256);
      end
      test_reset();
      test_basic();
      test_backpressure();
      test_early_last();
      test_timeout();
      test_reset_mid();
      test_clr_collision();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired before completion");
      $fatal(1);
   end

endmodule
